// File: rtl/mac_lookup_requester.sv
// Initiator side of the MAC learning lookup: assembles dst/src MAC from the ingress
// byte stream, issues one lookup per frame and presents a registered forwarding decision.
module mac_lookup_requester #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = 7,
  parameter int MIN_HDR_BYTES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic [2:0]  rx_port,
  output logic        rx_ready,
  output logic        lu_en,
  output logic [47:0] lu_src_mac,
  output logic [47:0] lu_dst_mac,
  output logic [2:0]  lu_src_port,
  input  logic        lu_done,
  input  logic [2:0]  lu_dst_port,
  output logic        fwd_valid,
  input  logic        fwd_ready,
  output logic [2:0]  fwd_port,
  output logic        fwd_flood,
  output logic        fwd_timeout
);

  localparam int BC_W = $clog2(MIN_HDR_BYTES);
  localparam logic [BC_W-1:0]     LAST_IDX  = BC_W'(MIN_HDR_BYTES - 1);
  localparam logic [BC_W-1:0]     DST_BYTES = BC_W'(MIN_HDR_BYTES / 2);
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {HDR, REQ, WAIT, OUT, DRAIN} state_t;

  state_t              state;
  logic [BC_W-1:0]     byte_cnt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                hdr_last;
  logic                rx_xfer;
  logic [TO_WIDTH-1:0] to_cnt_next;
  logic                dst_group;

  assign rx_xfer     = rx_valid & rx_ready;
  assign to_cnt_next = to_cnt + 1'b1;
  // I/G bit of the first destination byte: set for multicast and broadcast.
  assign dst_group   = lu_dst_mac[40];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HDR;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      hdr_last    <= 1'b0;
      rx_ready    <= 1'b1;
      lu_en       <= 1'b0;
      lu_src_mac  <= '0;
      lu_dst_mac  <= '0;
      lu_src_port <= '0;
      fwd_valid   <= 1'b0;
      fwd_port    <= '0;
      fwd_flood   <= 1'b0;
      fwd_timeout <= 1'b0;
    end else begin
      lu_en <= 1'b0;
      case (state)
        HDR: if (rx_xfer) begin
          if (byte_cnt == '0) lu_src_port <= rx_port;
          // Shifting in from the LSB leaves the first wire byte in the MSB.
          if (byte_cnt < DST_BYTES) lu_dst_mac <= {lu_dst_mac[39:0], rx_data};
          else                      lu_src_mac <= {lu_src_mac[39:0], rx_data};
          if (byte_cnt == LAST_IDX) begin
            byte_cnt <= '0;
            hdr_last <= rx_last;
            lu_en    <= 1'b1;
            rx_ready <= 1'b0;
            state    <= REQ;
          end else if (rx_last) begin
            byte_cnt <= '0;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        REQ: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          to_cnt <= to_cnt_next;
          if (lu_done) begin
            fwd_port    <= dst_group ? lu_src_port : lu_dst_port;
            fwd_flood   <= dst_group;
            fwd_timeout <= 1'b0;
            fwd_valid   <= 1'b1;
            state       <= OUT;
          end else if (to_cnt_next == TO_LAST) begin
            fwd_port    <= lu_src_port;
            fwd_flood   <= 1'b1;
            fwd_timeout <= 1'b1;
            fwd_valid   <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: if (fwd_ready) begin
          fwd_valid <= 1'b0;
          rx_ready  <= 1'b1;
          state     <= hdr_last ? HDR : DRAIN;
        end
        DRAIN: if (rx_xfer && rx_last) state <= HDR;
        default: begin
          state    <= HDR;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lookup_requester.sv
// Scoreboard bench for mac_lookup_requester: stimulus pushes expected lookups and
// decisions, a monitor pops and compares on lu_en and on each fwd handshake.
module tb_mac_lookup_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic [2:0]  rx_port;
  logic        rx_ready;
  logic        lu_en;
  logic [47:0] lu_src_mac;
  logic [47:0] lu_dst_mac;
  logic [2:0]  lu_src_port;
  logic        lu_done;
  logic [2:0]  lu_dst_port;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [2:0]  fwd_port;
  logic        fwd_flood;
  logic        fwd_timeout;

  always #5 clk = ~clk;

  mac_lookup_requester dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_port(rx_port),
    .rx_ready(rx_ready),
    .lu_en(lu_en), .lu_src_mac(lu_src_mac), .lu_dst_mac(lu_dst_mac),
    .lu_src_port(lu_src_port), .lu_done(lu_done), .lu_dst_port(lu_dst_port),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_port(fwd_port),
    .fwd_flood(fwd_flood), .fwd_timeout(fwd_timeout)
  );

  typedef struct packed {logic [47:0] dst; logic [47:0] src; logic [2:0] port;} lu_exp_t;
  typedef struct packed {logic [2:0] port; logic flood; logic timeout;} fwd_exp_t;

  lu_exp_t  lu_q[$];
  fwd_exp_t fwd_q[$];
  lu_exp_t  le;
  fwd_exp_t fe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lu_cnt = 0;
  int lu_en_cyc = 0;
  logic lu_en_prev = 1'b0;

  int         resp_delay = 3;
  bit         resp_on = 1'b1;
  logic [2:0] resp_port = 3'd0;
  int         hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every lookup request and every consumed decision.
  always @(negedge clk) begin
    if (rst) begin
      if (lu_en) begin
        lu_cnt++;
        lu_en_cyc = cyc;
        check("lu_en_single_pulse", lu_en_prev, 0);
        if (lu_q.size() == 0) check("unexpected_lu_en", 1, 0);
        else begin
          le = lu_q.pop_front();
          check("lu_dst_mac", lu_dst_mac, le.dst);
          check("lu_src_mac", lu_src_mac, le.src);
          check("lu_src_port", lu_src_port, le.port);
        end
      end
      if (fwd_valid && fwd_ready) begin
        if (fwd_q.size() == 0) check("unexpected_fwd", 1, 0);
        else begin
          fe = fwd_q.pop_front();
          check("fwd_decision", {fwd_port, fwd_flood, fwd_timeout},
                {fe.port, fe.flood, fe.timeout});
        end
      end
    end
    lu_en_prev = lu_en;
  end

  // Learning-block responder: answers lu_en after resp_delay cycles.
  initial begin
    lu_done = 1'b0;
    lu_dst_port = 3'd0;
    forever begin
      @(negedge clk);
      if (rst && lu_en && resp_on) begin
        @(posedge clk);
        repeat (resp_delay - 1) @(posedge clk);
        #1;
        lu_done = 1'b1;
        lu_dst_port = resp_port;
        @(posedge clk);
        #1;
        lu_done = 1'b0;
      end
    end
  end

  // Downstream consumer: optionally stalls `hold` cycles, checking the decision stays put.
  logic [2:0] snap_port;
  logic       snap_flood, snap_to;
  initial begin
    fwd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && fwd_valid && !fwd_ready) begin
        snap_port = fwd_port;
        snap_flood = fwd_flood;
        snap_to = fwd_timeout;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("fwd_hold_stable", {fwd_valid, rx_ready, fwd_port, fwd_flood, fwd_timeout},
                {1'b1, 1'b0, snap_port, snap_flood, snap_to});
        end
        @(posedge clk);
        #1 fwd_ready = 1'b1;
        @(posedge clk);
        #1 fwd_ready = 1'b0;
      end
    end
  end

  task automatic expect_lu(input logic [47:0] d, input logic [47:0] s, input logic [2:0] p);
    lu_q.push_back('{dst: d, src: s, port: p});
  endtask

  task automatic expect_fwd(input logic [2:0] p, input logic fl, input logic to);
    fwd_q.push_back('{port: p, flood: fl, timeout: to});
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic [2:0] p,
                           input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
    rx_data = d;
    rx_last = last;
    rx_port = p;
    rx_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      t++;
      if (t >= 500) begin
        check("byte_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic send_hdr(input logic [2:0] p, input logic [47:0] d, input logic [47:0] s,
                          input logic last, input bit gaps);
    logic [95:0] hdr;
    hdr = {d, s};
    for (int k = 0; k < 12; k++)
      send_byte(hdr[95 - 8*k -: 8], last && (k == 11), p,
                gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i + 8'h40), i == n - 1, 3'd0, 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((lu_q.size() != 0 || fwd_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 2000) check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {rx_ready, lu_en, fwd_valid, fwd_port, fwd_flood, fwd_timeout, lu_src_port},
          {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0});
    check({tag, "_src_mac"}, lu_src_mac, 0);
    check({tag, "_dst_mac"}, lu_dst_mac, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation still running, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int t, c0;
    rst = 1'b0;
    rx_data = 8'd0;
    rx_valid = 1'b0;
    rx_last = 1'b0;
    rx_port = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Unicast frame with 20-byte payload, answer 3 cycles after lu_en.
    resp_delay = 3;
    resp_port = 3'd5;
    expect_lu(48'h001122334455, 48'h66778899aabb, 3'd3);
    expect_fwd(3'd5, 1'b0, 1'b0);
    send_hdr(3'd3, 48'h001122334455, 48'h66778899aabb, 1'b0, 1'b0);
    @(negedge clk);
    check("rx_ready_low_after_hdr", rx_ready, 0);
    @(posedge clk);
    #1;
    send_payload(20);
    wait_idle();
    @(negedge clk);
    check("rx_ready_after_drain", rx_ready, 1);
    @(posedge clk);
    #1;

    // Broadcast destination floods with the ingress port.
    resp_port = 3'd2;
    expect_lu(48'hffffffffffff, 48'h0a0b0c0d0e0f, 3'd1);
    expect_fwd(3'd1, 1'b1, 1'b0);
    send_hdr(3'd1, 48'hffffffffffff, 48'h0a0b0c0d0e0f, 1'b0, 1'b0);
    send_payload(4);
    wait_idle();

    // No response: timeout decision exactly 64 cycles after the lu_en cycle.
    resp_on = 1'b0;
    expect_lu(48'h020000000001, 48'h123456789abc, 3'd6);
    expect_fwd(3'd6, 1'b1, 1'b1);
    send_hdr(3'd6, 48'h020000000001, 48'h123456789abc, 1'b1, 1'b0);
    t = 0;
    forever begin
      @(negedge clk);
      if (fwd_valid) break;
      t++;
      if (t >= 300) begin
        check("timeout_never_fired", 0, 1);
        break;
      end
    end
    check("timeout_latency", cyc - lu_en_cyc, 64);
    @(posedge clk);
    #1;
    wait_idle();
    resp_on = 1'b1;

    // 8-byte runt, then a multicast-destination frame.
    c0 = lu_cnt;
    for (int k = 0; k < 8; k++) send_byte(8'(8'h10 + k), k == 7, 3'd4, 0);
    repeat (5) @(posedge clk);
    #1;
    check("runt_no_lookup", lu_cnt, c0);
    resp_port = 3'd7;
    expect_lu(48'h0123456789ab, 48'h00aabbccddee, 3'd4);
    expect_fwd(3'd4, 1'b1, 1'b0);
    send_hdr(3'd4, 48'h0123456789ab, 48'h00aabbccddee, 1'b0, 1'b0);
    send_payload(5);
    wait_idle();
    check("one_lookup_after_runt", lu_cnt, c0 + 1);

    // Header with random rx_valid gaps, decision stalled 10 cycles.
    hold = 10;
    resp_port = 3'd0;
    expect_lu(48'h3c4d5e6f7081, 48'h8899aabbccdd, 3'd2);
    expect_fwd(3'd0, 1'b0, 1'b0);
    send_hdr(3'd2, 48'h3c4d5e6f7081, 48'h8899aabbccdd, 1'b0, 1'b1);
    send_payload(3);
    wait_idle();
    hold = 0;

    // Reset while waiting; late lu_done must be ignored.
    resp_delay = 8;
    expect_lu(48'h001a2b3c4d5e, 48'h00fedcba9876, 3'd5);
    send_hdr(3'd5, 48'h001a2b3c4d5e, 48'h00fedcba9876, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midop_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    c0 = lu_cnt;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_fwd_after_reset", fwd_valid, 0);
    end
    check("no_lookup_after_reset", lu_cnt, c0);
    @(posedge clk);
    #1;
    resp_delay = 3;
    resp_port = 3'd6;
    expect_lu(48'haabbccddeeff, 48'h112233445566, 3'd0);
    expect_fwd(3'd6, 1'b0, 1'b0);
    send_hdr(3'd0, 48'haabbccddeeff, 48'h112233445566, 1'b0, 1'b0);
    send_payload(2);
    wait_idle();

    repeat (5) @(posedge clk);
    check("queues_empty", lu_q.size() + fwd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
